// File: rtl/vrisc_core_pkg.sv
// Shared encodings for the vrisc_core accumulator machine: opcodes, control states
// and a small decode helper used by the core.
package opcodes;

  localparam int unsigned OPCODE_WIDTH = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_t;

  // Control-flow instructions finish in DECODE and never touch the data bus.
  function automatic logic retires_in_decode(input opcode_t op);
    return (op == HLT) || (op == SKZ) || (op == JMP);
  endfunction

endpackage

// File: rtl/vrisc_alu.sv
// Combinational accumulator datapath for vrisc_core: computes the value the
// accumulator takes when an EXEC memory transaction completes.
module vrisc_alu
  import opcodes::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  opcode_t               opcode,
  input  logic [DATA_WIDTH-1:0] accum,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    // NOTE: result gets a value before the case so no path leaves it unassigned (no latch).
    result = accum;
    case (opcode)
      ADD:     result = accum + data;
      AND:     result = accum & data;
      XOR:     result = accum ^ data;
      LDA:     result = data;
      default: result = accum;
    endcase
  end

endmodule

// File: rtl/vrisc_core.sv
// vrisc_core: multi-cycle accumulator CPU (FETCH/DECODE/EXEC/HALT) with a req/ready
// memory port. Define VRISC_PERF_CNT_EN to build the retired-instruction counter.
module vrisc_core
  import opcodes::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  load_ir,
  output logic                  halt,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  if (DATA_WIDTH < ADDR_WIDTH + OPCODE_WIDTH) begin : g_width_check
    $error("vrisc_core: DATA_WIDTH must be at least ADDR_WIDTH + 3");
  end

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] accum_q, accum_d;
  logic [DATA_WIDTH-1:0] alu_result;
  opcode_t               opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic                  zero;
  logic                  xfer;

  assign opcode  = opcode_t'(ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH]);
  assign operand = ir_q[ADDR_WIDTH-1:0];
  assign zero    = (accum_q == '0);

  // Bus strobes come from the state register only; gating with rst drops a
  // pending request the moment reset asserts.
  assign mem_req   = rst && ((state_q == FETCH) || (state_q == EXEC));
  assign mem_we    = mem_req && (state_q == EXEC) && (opcode == STO);
  assign mem_addr  = (state_q == EXEC) ? operand : pc_q;
  assign mem_wdata = accum_q;
  assign xfer      = mem_req && mem_ready;
  assign load_ir   = xfer && (state_q == FETCH);
  assign halt      = (state_q == HALT);

  vrisc_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .opcode(opcode),
    .accum (accum_q),
    .data  (mem_rdata),
    .result(alu_result)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    accum_d = accum_q;
    case (state_q)
      FETCH: begin
        if (xfer) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          HLT: state_d = HALT;
          SKZ: begin
            state_d = FETCH;
            if (zero) pc_d = pc_q + ADDR_WIDTH'(1);
          end
          JMP: begin
            state_d = FETCH;
            pc_d    = operand;
          end
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin
        if (xfer) begin
          accum_d = alu_result;
          state_d = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      accum_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      accum_q <= accum_d;
    end
  end

`ifdef VRISC_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] count_q;
  logic                 retire;

  assign retire = ((state_q == DECODE) && retires_in_decode(opcode)) ||
                  ((state_q == EXEC) && xfer);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: doc/vrisc_core.md
VRISC_CORE -- requirements
Module: vrisc_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: accumulator, memory word and instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: PC, operand address and memory address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: retired-instruction counter width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst as in the rest of the codebase.
REQ-005 SHALL have these ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- mem_req  output  1  memory transaction request
- mem_we  output  1  1 = write, 0 = read; valid while mem_req = 1
- mem_addr  output  ADDR_WIDTH  transaction address
- mem_wdata  output  DATA_WIDTH  write data (the accumulator)
- mem_rdata  input  DATA_WIDTH  read data; valid when mem_ready = 1
- mem_ready  input  1  transaction completes on a clk edge where mem_req and mem_ready are both 1
- load_ir  output  1  high in the cycle the instruction register captures
- halt  output  1  core halted
- instr_count  output  CNT_WIDTH  retired-instruction count

Function
REQ-006 Instruction word SHALL be: opcode = bits [DATA_WIDTH-1 -: 3], operand address = bits [ADDR_WIDTH-1:0].
- DATA_WIDTH >= ADDR_WIDTH+3 SHALL be enforced by an elaboration-time assertion.
REQ-007 Opcodes SHALL be: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-008 Control SHALL be an FSM with states FETCH, DECODE, EXEC and HALT.
REQ-009 FETCH:
- mem_req=1, mem_we=0, mem_addr=pc.
- On the ready edge: ir<=mem_rdata, pc<=pc+1, next state DECODE.
- load_ir = FETCH & mem_req & mem_ready.
REQ-010 DECODE (exactly one cycle, mem_req=0):
- HLT -> HALT.
- SKZ: if zero, pc<=pc+1; -> FETCH.
- JMP: pc<=operand; -> FETCH.
- All other opcodes -> EXEC.
REQ-011 EXEC:
- mem_req=1, mem_addr=operand, mem_we=(opcode==STO), mem_wdata=accum.
- On the ready edge: ADD accum<=accum+rdata (wrap, carry discarded); AND/XOR bitwise; LDA accum<=rdata; STO accum unchanged; -> FETCH.
REQ-012 The FSM SHALL hold its state, with mem_req high and address and data stable, for every cycle mem_ready=0 (unbounded wait states).
REQ-013 zero SHALL equal (accum==0), evaluated on the registered accumulator.
REQ-014 PC SHALL wrap modulo 2**ADDR_WIDTH, including the SKZ double increment.
REQ-015 Zero-wait latency SHALL be 3 cycles for ADD/AND/XOR/LDA/STO and 2 cycles for SKZ/JMP/HLT.
REQ-016 HALT:
- Sticky until reset.
- halt=1, mem_req=0.
- pc, accum and instr_count frozen.
REQ-017 mem_req SHALL never be asserted in DECODE or HALT.
REQ-018 mem_req SHALL be registered-state-derived only, with no combinational path from mem_ready.

Reset
REQ-019 While rst=0, these SHALL be forced: state=FETCH, pc=0, accum=0, ir=0, instr_count=0, mem_req=0, halt=0, load_ir=0.
REQ-020 Reset asserted mid-transaction SHALL drop mem_req asynchronously and abort the transaction, with no register update.
REQ-021 The first mem_req (addr 0) SHALL assert in the first cycle after rst deasserts.

Configuration
REQ-022 The macro VRISC_PERF_CNT_EN SHALL control the retired-instruction counter.
- Defined: instr_count increments by 1 on each instruction completion (DECODE exit for SKZ/JMP/HLT, EXEC ready edge otherwise) and wraps at 2**CNT_WIDTH.
- Undefined: no counter logic; instr_count is tied to 0.

Structure
REQ-023 opcode_t (3-bit enum) and state_t (FETCH/DECODE/EXEC/HALT enum) SHALL live in the shared package opcodes.
REQ-024 The datapath arithmetic SHALL be the sub-module vrisc_alu: combinational, parametrised by DATA_WIDTH, inputs opcode, accum and data, output result.

Verification (DATA_WIDTH=8, ADDR_WIDTH=5, mem_ready=1 unless stated)
REQ-025 Program LDA 0x1E, ADD 0x1F, STO 0x1D, HLT with mem[1E]=0x05 and mem[1F]=0x03 -> mem[1D]=0x08, halt=1 at cycle 11, instr_count=4.
REQ-026 ADD of 0xFF+0x02 -> accum=0x01 (wrap); then XOR with 0x01 -> accum=0, and the following SKZ skips the next instruction (pc advances by 2).
REQ-027 JMP 0x1F from pc 0x1E, then SKZ at 0x1F with zero=1 -> next fetch addresses 0x01 (wrap).
REQ-028 Hold mem_ready=0 for 4 cycles during an EXEC STO -> mem_req, mem_we, mem_addr and mem_wdata stay stable for 5 cycles; exactly one write.
REQ-029 Assert rst=0 mid-FETCH wait, then release -> mem_req low immediately; next request is to addr 0 with accum=0.
REQ-030 Build without VRISC_PERF_CNT_EN -> instr_count stays 0 through REQ-025.
